// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side bundle of the RV32I decode stage.
// The stage is the slave; the fetch/execute environment is the master.
interface decode_stage_if #(
  parameter int unsigned PC_WIDTH = 32
) ();
  // Fetch side
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  // Execute side
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [4:0]          out_rd;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [2:0]          out_funct3;
  logic [31:0]         out_imm;
  logic [3:0]          out_alu_op;
  logic                out_alu_src;
  logic                out_a_pc;
  logic                out_branch;
  logic                out_jump;
  logic                out_mem_read;
  logic                out_mem_write;
  logic                out_reg_write;
  logic                out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_imm,
           out_alu_op, out_alu_src, out_a_pc, out_branch, out_jump, out_mem_read,
           out_mem_write, out_reg_write, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_imm,
           out_alu_op, out_alu_src, out_a_pc, out_branch, out_jump, out_mem_read,
           out_mem_write, out_reg_write, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage (no SYSTEM/FENCE) with valid/ready handshake,
// flush, optional 2-entry skid buffer and a saturating illegal-bundle counter.
module decode_stage #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned SKID      = 0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  decode_stage_if.slave        bus,
  output logic [CNT_WIDTH-1:0] illegal_count
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_SEQ  = 4'd10;
  localparam logic [3:0] ALU_SNE  = 4'd11;
  localparam logic [3:0] ALU_SGT  = 4'd12;
  localparam logic [3:0] ALU_SGTU = 4'd13;
  localparam logic [3:0] ALU_NONE = 4'd15;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [31:0]         imm;
    logic [3:0]          alu_op;
    logic                alu_src;
    logic                a_pc;
    logic                branch;
    logic                jump;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                illegal;
  } bundle_t;

  // Register-register / register-immediate arithmetic shares one funct3 map.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal;
  bundle_t     dec;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct7 = instr[31:25];
  assign f3     = instr[14:12];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  // Combinational decode of the incoming word; illegal words keep only the fields.
  always_comb begin
    dec        = '0;
    legal      = 1'b0;
    dec.pc     = bus.in_pc;
    dec.rd     = instr[11:7];
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.funct3 = f3;
    case (opcode)
      OPCODE_LOAD: begin
        legal        = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        dec.imm      = imm_i;
        dec.alu_op   = ALU_ADD;
        dec.alu_src  = 1'b1;
        dec.mem_read = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPCODE_STORE: begin
        legal         = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        dec.imm       = imm_s;
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OPCODE_OP: begin
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        dec.alu_op    = arith_op(f3, instr[30]);
        dec.reg_write = 1'b1;
      end
      OPCODE_OP_IMM: begin
        if (f3 == 3'b001) begin
          legal = (funct7 == 7'b0000000);
        end else if (f3 == 3'b101) begin
          legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end else begin
          legal = 1'b1;
        end
        dec.imm       = imm_i;
        // Only shifts carry an alternate form in the immediate's funct7 bits.
        dec.alu_op    = arith_op(f3, (f3 == 3'b101) && instr[30]);
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPCODE_BRANCH: begin
        legal      = (f3 != 3'b010) && (f3 != 3'b011);
        dec.imm    = imm_b;
        dec.branch = 1'b1;
        case (f3)
          3'b000:  dec.alu_op = ALU_SEQ;
          3'b001:  dec.alu_op = ALU_SNE;
          3'b100:  dec.alu_op = ALU_SLT;
          3'b101:  dec.alu_op = ALU_SGT;
          3'b110:  dec.alu_op = ALU_SLTU;
          default: dec.alu_op = ALU_SGTU;
        endcase
      end
      OPCODE_LUI: begin
        legal         = 1'b1;
        dec.rs1       = 5'd0;
        dec.imm       = imm_u;
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPCODE_AUIPC: begin
        legal         = 1'b1;
        dec.imm       = imm_u;
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.a_pc      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPCODE_JAL: begin
        legal         = 1'b1;
        dec.imm       = imm_j;
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.a_pc      = 1'b1;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPCODE_JALR: begin
        legal         = (f3 == 3'b000);
        dec.imm       = imm_i;
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.a_pc      = 1'b1;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Opcode table covers instr[1:0]!=11 and the all-zero word as well.
    if (!legal) begin
      dec.rs1       = instr[19:15];
      dec.imm       = '0;
      dec.alu_op    = ALU_NONE;
      dec.alu_src   = 1'b0;
      dec.a_pc      = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.reg_write = 1'b0;
      dec.illegal   = 1'b1;
    end
  end

  bundle_t              out_q, out_d, skid_q, skid_d;
  logic                 out_valid_q, out_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic                 ready_q, ready_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 in_ready;
  logic                 accept, out_fire;

  assign in_ready = (SKID != 0) ? (ready_q & ~flush)
                                : (~flush & (~out_valid_q | bus.out_ready));
  assign accept   = bus.in_valid & in_ready;
  assign out_fire = out_valid_q & bus.out_ready;

  // Next state of output register, skid slot and registered ready.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_fire) begin
      // Skid is older than anything accepted now, so it drains first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept && (SKID != 0)) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    ready_d = ~skid_valid_d;
  end

  // Saturating count of illegal bundles handed to execute.
  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && out_q.illegal && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc        = out_q.pc;
  assign bus.out_rd        = out_q.rd;
  assign bus.out_rs1       = out_q.rs1;
  assign bus.out_rs2       = out_q.rs2;
  assign bus.out_funct3    = out_q.funct3;
  assign bus.out_imm       = out_q.imm;
  assign bus.out_alu_op    = out_q.alu_op;
  assign bus.out_alu_src   = out_q.alu_src;
  assign bus.out_a_pc      = out_q.a_pc;
  assign bus.out_branch    = out_q.branch;
  assign bus.out_jump      = out_q.jump;
  assign bus.out_mem_read  = out_q.mem_read;
  assign bus.out_mem_write = out_q.mem_write;
  assign bus.out_reg_write = out_q.reg_write;
  assign bus.out_illegal   = out_q.illegal;
  assign illegal_count     = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of decode vectors on a SKID=0 instance,
// plus hand sequences for reset, counter, flush and the SKID=1 buffer.
module tb_decode_stage;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] XOR  = 4'd5;
  localparam logic [3:0] SRA  = 4'd7;
  localparam logic [3:0] AND  = 4'd9;
  localparam logic [3:0] SEQ  = 4'd10;
  localparam logic [3:0] SGTU = 4'd13;
  localparam logic [3:0] NONE = 4'd15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush0 = 1'b0;
  logic        flush1 = 1'b0;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  decode_stage_if #(.PC_WIDTH(32)) bus0 ();
  decode_stage_if #(.PC_WIDTH(32)) bus1 ();

  decode_stage #(.PC_WIDTH(32), .SKID(0), .CNT_WIDTH(16)) dut0 (
    .clock(clock), .reset(reset), .flush(flush0), .bus(bus0.slave), .illegal_count(cnt0)
  );
  decode_stage #(.PC_WIDTH(32), .SKID(1), .CNT_WIDTH(2)) dut1 (
    .clock(clock), .reset(reset), .flush(flush1), .bus(bus1.slave), .illegal_count(cnt1)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [7:0]  ctrl;  // {alu_src,a_pc,branch,jump,mem_read,mem_write,reg_write,illegal}
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [2:0]  f3;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ctrl0();
    return {bus0.out_alu_src, bus0.out_a_pc, bus0.out_branch, bus0.out_jump,
            bus0.out_mem_read, bus0.out_mem_write, bus0.out_reg_write, bus0.out_illegal};
  endfunction

  initial begin
    logic [31:0] ins;
    int idx;
    int got;
    logic [31:0] held_pc;

    vecs[0]  = '{32'hFFB00093, 32'hFFFFFFFB, ADD,  8'b1000_0010, 5'd1,  5'd0,  3'd0};
    vecs[1]  = '{32'h001000EF, 32'h00000800, ADD,  8'b1101_0010, 5'd1,  5'd0,  3'd0};
    vecs[2]  = '{32'h123452B7, 32'h12345000, ADD,  8'b1000_0010, 5'd5,  5'd0,  3'd5};
    vecs[3]  = '{32'h80000197, 32'h80000000, ADD,  8'b1100_0010, 5'd3,  5'd0,  3'd0};
    vecs[4]  = '{32'hFFC52103, 32'hFFFFFFFC, ADD,  8'b1000_1010, 5'd2,  5'd10, 3'd2};
    vecs[5]  = '{32'h00512423, 32'h00000008, ADD,  8'b1000_0100, 5'd8,  5'd2,  3'd2};
    vecs[6]  = '{32'hFE118A23, 32'hFFFFFFF4, ADD,  8'b1000_0100, 5'd20, 5'd3,  3'd0};
    vecs[7]  = '{32'hFE208CE3, 32'hFFFFFFF8, SEQ,  8'b0010_0000, 5'd25, 5'd1,  3'd0};
    vecs[8]  = '{32'h0020F863, 32'h00000010, SGTU, 8'b0010_0000, 5'd16, 5'd1,  3'd7};
    vecs[9]  = '{32'h0020A863, 32'h00000000, NONE, 8'b0000_0001, 5'd16, 5'd1,  3'd2};
    vecs[10] = '{32'h004280E7, 32'h00000004, ADD,  8'b1101_0010, 5'd1,  5'd5,  3'd0};
    vecs[11] = '{32'h004290E7, 32'h00000000, NONE, 8'b0000_0001, 5'd1,  5'd5,  3'd1};
    vecs[12] = '{32'h402081B3, 32'h00000000, SUB,  8'b0000_0010, 5'd3,  5'd1,  3'd0};
    vecs[13] = '{32'h4062D233, 32'h00000000, SRA,  8'b0000_0010, 5'd4,  5'd5,  3'd5};
    vecs[14] = '{32'h40001033, 32'h00000000, NONE, 8'b0000_0001, 5'd0,  5'd0,  3'd1};
    vecs[15] = '{32'h4030D093, 32'h00000403, SRA,  8'b1000_0010, 5'd1,  5'd1,  3'd5};
    vecs[16] = '{32'h40309093, 32'h00000000, NONE, 8'b0000_0001, 5'd1,  5'd1,  3'd1};
    vecs[17] = '{32'hFFC53103, 32'h00000000, NONE, 8'b0000_0001, 5'd2,  5'd10, 3'd3};
    vecs[18] = '{32'h00000000, 32'h00000000, NONE, 8'b0000_0001, 5'd0,  5'd0,  3'd0};
    vecs[19] = '{32'h00004501, 32'h00000000, NONE, 8'b0000_0001, 5'd10, 5'd0,  3'd4};
    vecs[20] = '{32'hFFF44393, 32'hFFFFFFFF, XOR,  8'b1000_0010, 5'd7,  5'd8,  3'd4};
    vecs[21] = '{32'h003170B3, 32'h00000000, AND,  8'b0000_0010, 5'd1,  5'd2,  3'd7};

    bus0.in_valid = 1'b0; bus0.in_instr = '0; bus0.in_pc = '0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_instr = '0; bus1.in_pc = '0; bus1.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst out_valid", {31'b0, bus0.out_valid}, 32'd0);
    chk("rst imm", bus0.out_imm, 32'd0);
    chk("rst count", {16'b0, cnt0}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst in_ready", {31'b0, bus0.in_ready}, 32'd1);
    chk("rst skid in_ready", {31'b0, bus1.in_ready}, 32'd1);

    // Streamed table of decode vectors
    for (int i = 0; i < 22; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_instr = vecs[i].instr;
      bus0.in_pc    = 32'h100 + 32'(4 * i);
      @(negedge clock);
      ins = vecs[i].instr;
      chk($sformatf("v%0d valid", i), {31'b0, bus0.out_valid}, 32'd1);
      chk($sformatf("v%0d pc", i), bus0.out_pc, 32'h100 + 32'(4 * i));
      chk($sformatf("v%0d rd", i), {27'b0, bus0.out_rd}, {27'b0, vecs[i].rd});
      chk($sformatf("v%0d rs1", i), {27'b0, bus0.out_rs1}, {27'b0, vecs[i].rs1});
      chk($sformatf("v%0d rs2", i), {27'b0, bus0.out_rs2}, {27'b0, ins[24:20]});
      chk($sformatf("v%0d funct3", i), {29'b0, bus0.out_funct3}, {29'b0, vecs[i].f3});
      chk($sformatf("v%0d imm", i), bus0.out_imm, vecs[i].imm);
      chk($sformatf("v%0d alu_op", i), {28'b0, bus0.out_alu_op}, {28'b0, vecs[i].alu});
      chk($sformatf("v%0d ctrl", i), {24'b0, ctrl0()}, {24'b0, vecs[i].ctrl});
    end
    bus0.in_valid = 1'b0;
    @(negedge clock);
    chk("table count", {16'b0, cnt0}, 32'd7);
    chk("drained valid", {31'b0, bus0.out_valid}, 32'd0);

    // Asynchronous reset while a bundle is held
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.in_instr  = 32'h00000000;
    @(negedge clock);
    bus0.in_valid = 1'b0;
    chk("pre-reset valid", {31'b0, bus0.out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset valid", {31'b0, bus0.out_valid}, 32'd0);
    chk("async reset count", {16'b0, cnt0}, 32'd0);
    chk("async reset illegal", {31'b0, bus0.out_illegal}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post-reset in_ready", {31'b0, bus0.in_ready}, 32'd1);

    // Zero word then SLL with funct7 0100000: both illegal and both counted
    bus0.out_ready = 1'b1;
    bus0.in_valid  = 1'b1;
    bus0.in_instr  = 32'h00000000;
    @(negedge clock);
    chk("zero illegal", {31'b0, bus0.out_illegal}, 32'd1);
    chk("zero ctrl", {24'b0, ctrl0()}, 32'h01);
    bus0.in_instr = 32'h40001033;
    @(negedge clock);
    chk("sll alt illegal", {31'b0, bus0.out_illegal}, 32'd1);
    chk("sll alt alu", {28'b0, bus0.out_alu_op}, {28'b0, NONE});
    bus0.in_valid = 1'b0;
    @(negedge clock);
    chk("pair count", {16'b0, cnt0}, 32'd2);

    // Flush with a held illegal bundle and a new word offered
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.in_instr  = 32'h00000000;
    @(negedge clock);
    chk("flush pre valid", {31'b0, bus0.out_valid}, 32'd1);
    flush0 = 1'b1;
    bus0.in_instr = 32'hFFB00093;
    #1;
    chk("flush in_ready", {31'b0, bus0.in_ready}, 32'd0);
    @(negedge clock);
    flush0 = 1'b0;
    bus0.in_valid = 1'b0;
    chk("flush valid", {31'b0, bus0.out_valid}, 32'd0);
    chk("flush count", {16'b0, cnt0}, 32'd2);
    bus0.out_ready = 1'b1;

    // Skid buffer: stall 3 cycles while offering 4 illegal words (rd = index)
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      bus1.in_valid = 1'b1;
      bus1.in_instr = 32'(idx) << 7;
      bus1.in_pc    = 32'h200 + 32'(4 * idx);
      #1;
      if (bus1.in_ready) idx++;
      @(negedge clock);
    end
    chk("skid accepted", 32'(idx), 32'd2);
    chk("skid in_ready low", {31'b0, bus1.in_ready}, 32'd0);
    held_pc = bus1.out_pc;
    chk("skid held pc", held_pc, 32'h200);
    got = 0;
    bus1.out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      bus1.in_valid = (idx < 4);
      bus1.in_instr = 32'(idx) << 7;
      bus1.in_pc    = 32'h200 + 32'(4 * idx);
      #1;
      if (bus1.out_valid && bus1.out_ready) begin
        chk($sformatf("skid order pc%0d", got), bus1.out_pc, 32'h200 + 32'(4 * got));
        chk($sformatf("skid order rd%0d", got), {27'b0, bus1.out_rd}, 32'(got));
        got++;
      end
      if (bus1.in_valid && bus1.in_ready) idx++;
      @(negedge clock);
    end
    bus1.in_valid = 1'b0;
    chk("skid delivered", 32'(got), 32'd4);
    @(negedge clock);
    chk("skid empty valid", {31'b0, bus1.out_valid}, 32'd0);
    chk("skid count saturates", {30'b0, cnt1}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
